// File: rtl/muldiv_unit_pkg.sv
// Shared instruction definitions for decode and execute: 8-bit M-extension
// instruction codes, the multiply/divide FSM state encoding, the captured
// operation descriptor and small decode helpers.
package muldiv_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [7:0] INST_MUL    = 8'h01;
  localparam logic [7:0] INST_MULH   = 8'h02;
  localparam logic [7:0] INST_MULHSU = 8'h03;
  localparam logic [7:0] INST_MULHU  = 8'h04;
  localparam logic [7:0] INST_DIV    = 8'h05;
  localparam logic [7:0] INST_DIVU   = 8'h06;
  localparam logic [7:0] INST_REM    = 8'h07;
  localparam logic [7:0] INST_REMU   = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // sel_hi: high product word for the MUL group, remainder for the DIV group.
  typedef struct packed {
    logic is_div;
    logic sel_hi;
    logic a_signed;
    logic b_signed;
  } md_op_t;

  function automatic logic inst_legal(input logic [7:0] inst);
    return (inst >= INST_MUL) && (inst <= INST_REMU);
  endfunction

  function automatic md_op_t inst_decode(input logic [7:0] inst);
    md_op_t op;
    op = '0;
    case (inst)
      INST_MULH:   begin op.sel_hi = 1'b1; op.a_signed = 1'b1; op.b_signed = 1'b1; end
      INST_MULHSU: begin op.sel_hi = 1'b1; op.a_signed = 1'b1; end
      INST_MULHU:  op.sel_hi = 1'b1;
      INST_DIV:    begin op.is_div = 1'b1; op.a_signed = 1'b1; op.b_signed = 1'b1; end
      INST_DIVU:   op.is_div = 1'b1;
      INST_REM:    begin op.is_div = 1'b1; op.sel_hi = 1'b1; op.a_signed = 1'b1; op.b_signed = 1'b1; end
      INST_REMU:   begin op.is_div = 1'b1; op.sel_hi = 1'b1; end
      default:     op = '0;
    endcase
    return op;
  endfunction

  // Magnitude of an operand; 0x80000000 maps to 2^31 as an unsigned value.
  function automatic logic [XLEN-1:0] op_mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage request/response bundle of the multiply/divide unit.
//   inst_i        decoded instruction code
//   muldiv_inst_i request qualifier
//   reg1_data_i   rs1 operand, reg2_data_i rs2 operand
//   data_o        result, ready_o stall release, exception_o fault flag
interface muldiv_if;
  logic [7:0]  inst_i;
  logic        muldiv_inst_i;
  logic [31:0] reg1_data_i;
  logic [31:0] reg2_data_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        exception_o;

  modport master (
    output inst_i, muldiv_inst_i, reg1_data_i, reg2_data_i,
    input  data_o, ready_o, exception_o
  );

  modport slave (
    input  inst_i, muldiv_inst_i, reg1_data_i, reg2_data_i,
    output data_o, ready_o, exception_o
  );
endinterface

// File: rtl/muldiv_core_iter.sv
// Shared radix-2 datapath for multiply and divide, plus the iteration counter.
//   clk_i, rst_i  clock, async active-low reset
//   load_i        capture operand magnitudes (opa_i -> lo, opb_i -> b), clear hi/cnt
//   step_i        advance one iteration
//   is_div_i      selects restoring division (else shift-add multiply)
//   last_o        current step is the 32nd
//   hi_nxt_o/lo_nxt_o  register values after the current step
// Multiply: {hi,lo} is the product shifting right, lo starts as the multiplier.
// Divide:   hi is the partial remainder, lo shifts the dividend out and the
//           quotient bits in.
module muldiv_core_iter
  import muldiv_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] opa_i,
  input  logic [XLEN-1:0] opb_i,
  output logic            last_o,
  output logic [XLEN-1:0] hi_nxt_o,
  output logic [XLEN-1:0] lo_nxt_o
);
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [5:0]      cnt_q;
  logic [XLEN:0]   add_a, add_b, sum;
  logic            fits;

  // One 33-bit adder: subtract (a + ~b + 1) for divide, conditional add for multiply.
  always_comb begin
    add_a = is_div_i ? {hi_q, lo_q[XLEN-1]} : {1'b0, hi_q};
    if (is_div_i)      add_b = ~{1'b0, b_q};
    else if (lo_q[0])  add_b = {1'b0, b_q};
    else               add_b = '0;
    sum  = add_a + add_b + {{XLEN{1'b0}}, is_div_i};
    // Partial remainder < divisor keeps the trial difference within 33 bits,
    // so bit 32 alone tells a borrow.
    fits = ~sum[XLEN];
    if (is_div_i) begin
      hi_nxt_o = fits ? sum[XLEN-1:0] : add_a[XLEN-1:0];
      lo_nxt_o = {lo_q[XLEN-2:0], fits};
    end else begin
      hi_nxt_o = sum[XLEN:1];
      lo_nxt_o = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign last_o = (cnt_q == 6'd31);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      hi_q  <= '0;
      lo_q  <= opa_i;
      b_q   <= opb_i;
      cnt_q <= '0;
    end else if (step_i) begin
      hi_q  <= hi_nxt_o;
      lo_q  <= lo_nxt_o;
      cnt_q <= cnt_q + 6'd1;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// M-extension multiply/divide unit: IDLE/BUSY/DONE FSM, operand capture and
// sign fix-up around the iterative core.
//   clk_i  clock, rst_i async active-low reset
//   bus    muldiv_if.slave request/response bundle
// Build option: MULDIV_FAST_MUL_EN replaces the iterative MUL-group path
// with a single-cycle 33x33 signed multiplier (IDLE -> DONE directly).
// The core works on magnitudes; signs are re-applied on the final step so
// data_o is already valid in the DONE cycle when ready_o rises.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  muldiv_if.slave  bus
);
  md_state_e       state_q;
  md_op_t          op_q, dec;
  logic            sa_q, sb_q, divz_q, exc_q;
  logic [XLEN-1:0] data_q, hi_nxt, lo_nxt, res;
  logic [2*XLEN-1:0] prod;
  logic            last, req_ok, neg_prod, neg_rem;

  assign dec    = inst_decode(bus.inst_i);
  assign req_ok = (state_q == ST_IDLE) && bus.muldiv_inst_i && inst_legal(bus.inst_i);

  muldiv_core_iter u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (req_ok),
    .step_i   (state_q == ST_BUSY),
    .is_div_i (op_q.is_div),
    .opa_i    (op_mag(bus.reg1_data_i, dec.a_signed)),
    .opb_i    (op_mag(bus.reg2_data_i, dec.b_signed)),
    .last_o   (last),
    .hi_nxt_o (hi_nxt),
    .lo_nxt_o (lo_nxt)
  );

  // Sign fix-up. Divide-by-zero leaves quotient all ones and remainder equal
  // to the dividend magnitude in the core; only the quotient needs forcing.
  always_comb begin
    neg_prod = (op_q.a_signed & sa_q) ^ (op_q.b_signed & sb_q);
    neg_rem  = op_q.a_signed & sa_q;
    prod     = neg_prod ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    if (!op_q.is_div)  res = op_q.sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else if (op_q.sel_hi) res = neg_rem ? -hi_nxt : hi_nxt;
    else if (divz_q)   res = '1;
    else               res = neg_prod ? -lo_nxt : lo_nxt;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN-1:0] fprod;
  logic [XLEN-1:0]          fast_res;
  always_comb begin
    fa       = {dec.a_signed & bus.reg1_data_i[XLEN-1], bus.reg1_data_i};
    fb       = {dec.b_signed & bus.reg2_data_i[XLEN-1], bus.reg2_data_i};
    fprod    = fa * fb;
    fast_res = dec.sel_hi ? fprod[2*XLEN-1:XLEN] : fprod[XLEN-1:0];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      divz_q  <= 1'b0;
      data_q  <= '0;
      exc_q   <= 1'b0;
    end else begin
      exc_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.muldiv_inst_i) begin
          if (!inst_legal(bus.inst_i)) begin
            state_q <= ST_DONE;
            data_q  <= '0;
            exc_q   <= 1'b1;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!dec.is_div) begin
            state_q <= ST_DONE;
            data_q  <= fast_res;
          end
`endif
          else begin
            state_q <= ST_BUSY;
            op_q    <= dec;
            sa_q    <= bus.reg1_data_i[XLEN-1];
            sb_q    <= bus.reg2_data_i[XLEN-1];
            divz_q  <= dec.is_div && (bus.reg2_data_i == '0);
          end
        end
        ST_BUSY: if (last) begin
          state_q <= ST_DONE;
          data_q  <= res;
          exc_q   <= divz_q;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_o     = ((state_q == ST_IDLE) && !bus.muldiv_inst_i) || (state_q == ST_DONE);
  assign bus.data_o      = data_q;
  assign bus.exception_o = exc_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, reset abort,
// back-to-back requests and randomized operations against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_if bus();
  muldiv_unit dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [7:0] inst, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ub = longint'({32'b0, b});
    case (inst)
      INST_MUL:    begin p = sa * sb; return p[31:0]; end
      INST_MULH:   begin p = sa * sb; return p[63:32]; end
      INST_MULHSU: begin p = sa * ub; return p[63:32]; end
      INST_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      INST_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      INST_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      INST_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      INST_REMU: return (b == 0) ? a : a % b;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic ref_exc(input logic [7:0] inst, input logic [31:0] b);
    if (!(inst >= INST_MUL && inst <= INST_REMU)) return 1'b1;
    return (inst >= INST_DIV) && (b == 0);
  endfunction

  // Cycles with ready_o low, counting the request cycle itself.
  function automatic int ref_lat(input logic [7:0] inst);
    if (!(inst >= INST_MUL && inst <= INST_REMU)) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (inst <= INST_MULHU) return 1;
`endif
    return 33;
  endfunction

  // Issue one request. from_done: called in the DONE cycle of a held request,
  // so the new request is seen in the following IDLE cycle. hold: keep the
  // qualifier high after DONE for a back-to-back request.
  task automatic do_op(input string tag, input logic [7:0] inst, input logic [31:0] a,
                       input logic [31:0] b, input bit from_done, input bit hold);
    logic [31:0] er;
    logic        ee;
    int          lows;
    er = ref_res(inst, a, b);
    ee = ref_exc(inst, b);
    bus.inst_i        = inst;
    bus.reg1_data_i   = a;
    bus.reg2_data_i   = b;
    bus.muldiv_inst_i = 1'b1;
    if (from_done) @(negedge clk);
    #1;
    lows = 0;
    while (bus.ready_o === 1'b0 && lows < 100) begin
      lows++;
      @(negedge clk);
      bus.reg1_data_i = $urandom;
      bus.reg2_data_i = $urandom;
      #1;
    end
    check({tag, "_lat"},  32'(lows), 32'(ref_lat(inst)));
    check({tag, "_data"}, bus.data_o, er);
    check({tag, "_exc"},  {31'b0, bus.exception_o}, {31'b0, ee});
    if (!hold) begin
      bus.muldiv_inst_i = 1'b0;
      @(negedge clk);
      #1;
      check({tag, "_exc_clr"}, {31'b0, bus.exception_o}, 32'h0);
      check({tag, "_hold"},    bus.data_o, er);
      check({tag, "_rdy_idle"}, {31'b0, bus.ready_o}, 32'h1);
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [7:0] inst;
    bit prev_hold, hold;
    bit bad;
    rst_n             = 1'b0;
    bus.inst_i        = '0;
    bus.muldiv_inst_i = 1'b0;
    bus.reg1_data_i   = '0;
    bus.reg2_data_i   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data",  bus.data_o, 32'h0);
    check("rst_exc",   {31'b0, bus.exception_o}, 32'h0);
    check("rst_ready", {31'b0, bus.ready_o}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("mul7x6",   INST_MUL,    32'd7,         32'd6,         0, 0);
    do_op("mulh_m1",  INST_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op("mulhu_m1", INST_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_op("mulhsu",   INST_MULHSU, 32'hFFFF_FFFF, 32'd2,         0, 0);
    do_op("div_m7",   INST_DIV,    32'hFFFF_FFF9, 32'd2,         0, 0);
    do_op("rem_m7",   INST_REM,    32'hFFFF_FFF9, 32'd2,         0, 0);
    do_op("divu100",  INST_DIVU,   32'd100,       32'd7,         0, 0);
    do_op("remu100",  INST_REMU,   32'd100,       32'd7,         0, 0);
    do_op("div_z",    INST_DIV,    32'd5,         32'd0,         0, 0);
    do_op("remu_z",   INST_REMU,   32'd5,         32'd0,         0, 0);
    do_op("rem_mz",   INST_REM,    32'hFFFF_FFFB, 32'd0,         0, 0);
    do_op("div_ovf",  INST_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op("rem_ovf",  INST_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op("ill_00",   8'h00,       32'd1,         32'd1,         0, 0);
    do_op("ill_ff",   8'hFF,       32'd1,         32'd1,         0, 0);

    // Reset at BUSY cycle 10 aborts the operation.
    do_op("pre_rst",  INST_MUL,    32'h1234,      32'h10,        0, 0);
    bus.inst_i        = INST_MUL;
    bus.reg1_data_i   = 32'd5;
    bus.reg2_data_i   = 32'd5;
    bus.muldiv_inst_i = 1'b1;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_data",  bus.data_o, 32'h0);
    check("abort_exc",   {31'b0, bus.exception_o}, 32'h0);
    check("abort_idle",  {31'b0, bus.ready_o}, 32'h0);
    bus.muldiv_inst_i = 1'b0;
    #1;
    check("abort_ready", {31'b0, bus.ready_o}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.data_o !== 32'h0 || bus.exception_o !== 1'b0 || bus.ready_o !== 1'b1) bad = 1'b1;
    end
    check("abort_no_done", {31'b0, bad}, 32'h0);
    do_op("mul3x3",   INST_MUL,    32'd3,         32'd3,         0, 0);

    // Back-to-back with the qualifier held high.
    do_op("b2b_a",    INST_MUL,    32'd11,        32'd13,        0, 1);
    do_op("b2b_b",    INST_DIVU,   32'd1000,      32'd7,         1, 1);
    do_op("b2b_c",    INST_REM,    32'hFFFF_FF9C, 32'd7,         1, 0);

    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 8) == 8) inst = 8'(9 + $urandom_range(0, 246));
      else                           inst = 8'(INST_MUL + $urandom_range(0, 7));
      hold = (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0;
      do_op("rnd", inst, rnd_operand(), rnd_operand(), prev_hold, hold);
      prev_hold = hold;
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk_i  input  1  clock; all state changes on the rising edge.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 inst_i  input  8  decoded instruction code: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM or REMU.
REQ-005 muldiv_inst_i  input  1  request qualifier; high while an M-extension instruction sits in execute.
REQ-006 reg1_data_i  input  32  rs1 operand (multiplicand / dividend).
REQ-007 reg2_data_i  input  32  rs2 operand (multiplier / divisor).
REQ-008 data_o  output  32  result register.
REQ-009 ready_o  output  1  high when no operation is pending or the result is valid.
REQ-010 exception_o  output  1  one-cycle flag raised with the result for divide-by-zero or an illegal code.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-012 IDLE with muldiv_inst_i=1 and a legal inst_i SHALL capture the operands, the operation and the signedness, then go to BUSY.
REQ-013 BUSY SHALL run a radix-2 iteration for exactly 32 cycles and then go to DONE.
- MUL group: shift-add.
- DIV/REM group: restoring division on operand magnitudes.
REQ-014 In DONE the block SHALL load data_o, assert ready_o for one cycle, and return to IDLE.
REQ-015 ready_o SHALL equal (IDLE and not muldiv_inst_i) or DONE; it is combinational from state, so a new request stalls the pipeline in its first cycle.
REQ-016 Operand inputs SHALL be ignored after capture; input changes during BUSY have no effect.
REQ-017 After DONE the block SHALL spend one IDLE cycle; if muldiv_inst_i is still high there, it starts a new operation.
REQ-018 MUL SHALL return the low 32 bits of the product.
REQ-019 MULH, MULHSU and MULHU SHALL return the high 32 bits of the 64-bit product.
- MULH: signed x signed.
- MULHSU: signed rs1 x unsigned rs2.
- MULHU: unsigned x unsigned.
REQ-020 DIV and DIVU SHALL return the quotient truncated toward zero; REM and REMU SHALL return the remainder with the sign of the dividend.
REQ-021 For a divisor of 0, the quotient SHALL be 0xFFFFFFFF, the remainder SHALL be the dividend, and exception_o SHALL be 1 in DONE.
REQ-022 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give DIV=0x80000000 and REM=0, with no exception.
REQ-023 A request with an illegal inst_i SHALL go straight to DONE with data_o=0 and exception_o=1.
REQ-024 data_o SHALL hold its last result until the next DONE.

Reset
REQ-025 rst_i low SHALL immediately force IDLE, data_o=0, exception_o=0, and clear the counter and datapath registers.
REQ-026 ready_o after reset SHALL follow REQ-015, i.e. 1 while muldiv_inst_i=0.
REQ-027 Reset during BUSY SHALL abort the operation with no result or DONE pulse; after release the block waits in IDLE for a request.

Configuration
REQ-028 With macro MULDIV_FAST_MUL_EN defined, the MUL-group operations SHALL use a single-cycle 33x33 signed multiplier and go IDLE->DONE, so ready_o is high on the second cycle of the request.
REQ-029 Without MULDIV_FAST_MUL_EN, the MUL group SHALL use the 32-cycle iterative path; division is always iterative.

Structure
REQ-030 The 8-bit instruction codes (MUL..REMU) and the state encoding SHALL live in the shared instruction-definition package used by decode and execute.
REQ-031 The block SHALL contain one sub-module, muldiv_core_iter, that holds the shared shift/add-subtract datapath and the 6-bit iteration counter; the FSM and sign fix-up stay in muldiv_unit.

Verification
REQ-032 MUL 7 x 6 -> data_o=42, exception_o=0, ready_o low for 33 cycles and then high for 1 cycle (2 cycles total with MULDIV_FAST_MUL_EN).
REQ-033 MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU with the same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-034 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-035 DIV 5 / 0 -> 0xFFFFFFFF with exception_o=1; REMU 5 / 0 -> 5 with exception_o=1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with exception_o=0.
REQ-036 Pull rst_i low at BUSY cycle 10 -> IDLE immediately, data_o=0, no DONE pulse; a following MUL 3 x 3 -> 9.
REQ-037 Hold muldiv_inst_i high across two back-to-back requests with operands changed during BUSY -> results use the captured operands, and the second operation starts in the IDLE cycle after DONE.
